// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes rx, samples each bit once at mid-bit,
// and strobes each good byte or a framing error for one cycle.
module uart_receiver #(
    parameter int CLOCK_DIVIDE = 104
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       framing_error,
    output logic       busy
);

    localparam int HALF = CLOCK_DIVIDE / 2;
    localparam int TW   = $clog2(CLOCK_DIVIDE);
    localparam logic [TW-1:0] HALF_LOAD = TW'(HALF - 1);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLOCK_DIVIDE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bitIndex_q, bitIndex_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rxByte_q, rxByte_d;
    logic          received_q, received_d;
    logic          framingError_q, framingError_d;
    logic          rxMeta_q, rxSync_q;
    logic          timerExpired;

    assign timerExpired = (timer_q == '0);

    // Synchronizer flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rxMeta_q       <= 1'b1;
            rxSync_q       <= 1'b1;
            state_q        <= IDLE;
            timer_q        <= '0;
            bitIndex_q     <= '0;
            shift_q        <= '0;
            rxByte_q       <= '0;
            received_q     <= 1'b0;
            framingError_q <= 1'b0;
        end else begin
            rxMeta_q       <= rx;
            rxSync_q       <= rxMeta_q;
            state_q        <= state_d;
            timer_q        <= timer_d;
            bitIndex_q     <= bitIndex_d;
            shift_q        <= shift_d;
            rxByte_q       <= rxByte_d;
            received_q     <= received_d;
            framingError_q <= framingError_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        bitIndex_d     = bitIndex_q;
        shift_d        = shift_q;
        rxByte_d       = rxByte_q;
        received_d     = 1'b0;
        framingError_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rxSync_q) begin
                    state_d = START;
                    timer_d = HALF_LOAD;
                end
            end
            START: begin
                if (!timerExpired) begin
                    timer_d = timer_q - TW'(1);
                end else if (!rxSync_q) begin
                    state_d    = DATA;
                    timer_d    = BIT_LOAD;
                    bitIndex_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!timerExpired) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    shift_d = {rxSync_q, shift_q[7:1]};
                    timer_d = BIT_LOAD;
                    if (bitIndex_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIndex_d = bitIndex_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!timerExpired) begin
                    timer_d = timer_q - TW'(1);
                end else if (rxSync_q) begin
                    rxByte_d   = shift_q;
                    received_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    framingError_d = 1'b1;
                    state_d        = RECOVER;
                end
            end
            // A held-low break line reports one error, then waits for idle.
            RECOVER: begin
                if (rxSync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign received      = received_q;
    assign rx_byte       = rxByte_q;
    assign framing_error = framingError_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver with CLOCK_DIVIDE=8: expected bytes are
// queued as frames are driven and popped when received pulses.
module tb_uart_receiver;

    localparam int CD      = 8;
    localparam int HALF    = CD / 2;
    localparam int EXP_LAT = HALF + 9 * CD + 3;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       received;
    logic [7:0] rx_byte;
    logic       framing_error;
    logic       busy;

    int   checks     = 0;
    int   errors     = 0;
    int   cycle      = 0;
    int   startCycle = 0;
    int   rxSeen     = 0;
    int   rxPushed   = 0;
    int   feSeen     = 0;
    int   feExpected = 0;
    logic [7:0] lastGood = 8'h00;
    exp_t expQ[$];

    uart_receiver #(.CLOCK_DIVIDE(CD)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx            (rx),
        .received      (received),
        .rx_byte       (rx_byte),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Monitor: pop the scoreboard on each received strobe.
    always @(negedge clock) begin
        if (!reset) begin
            if (framing_error) begin
                feSeen++;
                checkOutput("fe_with_received", 32'(received), 32'd0);
            end
            if (received) begin
                rxSeen++;
                if (expQ.size() == 0) begin
                    checkOutput("spurious_received", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    int   lat;
                    e   = expQ.pop_front();
                    lat = cycle - e.start;
                    checkOutput("rx_byte", 32'(rx_byte), 32'(e.data));
                    checkOutput($sformatf("latency_window lat=%0d", lat),
                                32'((lat >= EXP_LAT - 1) && (lat <= EXP_LAT + 1)), 32'd1);
                end
            end
        end
    end

    // Leaves the caller at posedge+1 so frames can be chained with no gap.
    task automatic sendFrame(input logic [7:0] data, input logic stopBit,
                             input logic expectGood, input int resetAtBit);
        logic [9:0] frame;
        frame = {stopBit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            if (i == 0) begin
                startCycle = cycle;
                if (expectGood) begin
                    exp_t e;
                    e.data  = data;
                    e.start = startCycle;
                    expQ.push_back(e);
                    rxPushed++;
                    lastGood = data;
                end
            end
            if (i == 3) checkOutput("busy_mid_frame", 32'(busy), 32'd1);
            if (resetAtBit >= 0 && i == resetAtBit + 1) begin
                repeat (4) @(posedge clock);
                #1 reset = 1'b1;
                @(posedge clock);
                #1 reset = 1'b0;
                checkOutput("busy_after_reset", 32'(busy), 32'd0);
                repeat (3) @(posedge clock);
                #1;
            end else begin
                repeat (CD) @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 200 && expQ.size() != 0; i++) @(posedge clock);
        checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus();
        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        checkOutput("reset_received", 32'(received), 32'd0);
        checkOutput("reset_rx_byte", 32'(rx_byte), 32'd0);
        checkOutput("reset_framing_error", 32'(framing_error), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        idle(8);

        // 1: single frame
        sendFrame(8'h55, 1'b1, 1'b1, -1);
        idle(8);
        waitDrain();
        checkOutput("busy_after_frame", 32'(busy), 32'd0);

        // 2: back-to-back frames
        sendFrame(8'h01, 1'b1, 1'b1, -1);
        sendFrame(8'h0E, 1'b1, 1'b1, -1);
        sendFrame(8'hCD, 1'b1, 1'b1, -1);
        sendFrame(8'h42, 1'b1, 1'b1, -1);
        idle(8);
        waitDrain();

        // 3: start-bit glitch shorter than HALF
        rx = 1'b0;
        repeat (2) @(posedge clock);
        #1 rx = 1'b1;
        idle(12);
        checkOutput("busy_after_glitch", 32'(busy), 32'd0);
        checkOutput("rx_byte_after_glitch", 32'(rx_byte), 32'(lastGood));
        sendFrame(8'hA5, 1'b1, 1'b1, -1);
        idle(8);
        waitDrain();

        // 4: bad stop bit followed by a break
        sendFrame(8'h3C, 1'b0, 1'b0, -1);
        feExpected++;
        repeat (40) @(posedge clock);
        #1;
        checkOutput("busy_during_break", 32'(busy), 32'd1);
        idle(16);
        checkOutput("rx_byte_kept", 32'(rx_byte), 32'(lastGood));
        checkOutput("busy_after_break", 32'(busy), 32'd0);
        checkOutput("fe_count_after_break", 32'(feSeen), 32'(feExpected));
        sendFrame(8'h77, 1'b1, 1'b1, -1);
        idle(8);
        waitDrain();

        // 5: reset in the middle of data bit 4
        sendFrame(8'hFF, 1'b1, 1'b0, 4);
        idle(16);
        sendFrame(8'h12, 1'b1, 1'b1, -1);
        idle(8);
        waitDrain();

        // 6: extreme data values
        sendFrame(8'h00, 1'b1, 1'b1, -1);
        idle(8);
        waitDrain();
        sendFrame(8'hFF, 1'b1, 1'b1, -1);
        idle(8);
        waitDrain();
    endtask

    initial begin
        applyStimulus();
        idle(20);
        checkOutput("received_count", 32'(rxSeen), 32'(rxPushed));
        checkOutput("framing_error_count", 32'(feSeen), 32'(feExpected));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
